// File: rtl/tdes_pkg.sv
// Shared definitions for the 3DES block sequencer.
// State encoding, APB mode codes, key selectors and round counts.
package tdes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_HI,
        ST_LOAD_LO,
        ST_IP,
        ST_ROUND,
        ST_FP,
        ST_STORE_HI,
        ST_STORE_LO
    } state_t;

    localparam logic [2:0] MODE_IDLE = 3'd0;
    localparam logic [2:0] MODE_ENC  = 3'd1;
    localparam logic [2:0] MODE_DEC  = 3'd2;
    localparam logic [2:0] MODE_KEY1 = 3'd3;
    localparam logic [2:0] MODE_KEY2 = 3'd4;
    localparam logic [2:0] MODE_SRST = 3'd5;
    localparam logic [2:0] MODE_READ = 3'd6;

    localparam logic [1:0] KEY_K1 = 2'd0;
    localparam logic [1:0] KEY_K2 = 2'd1;
    localparam logic [1:0] KEY_K3 = 2'd2;

    localparam int ROUNDS_PER_PASS = 16;
    localparam int TOTAL_ROUNDS    = 48;

endpackage

// File: rtl/tdes_round_map.sv
// Maps the 0..47 round counter and block direction to key,
// subkey number and last-round flag for the DES round datapath.
module tdes_round_map
    import tdes_pkg::*;
(
    input  logic [5:0] i_rnd,
    input  logic       i_blk_dec,
    output logic [1:0] o_key_sel,
    output logic [3:0] o_subkey_idx,
    output logic       o_last_round
);

    logic [1:0] w_pass;
    logic [3:0] w_r;
    logic       w_pass_dec;

    assign w_pass = i_rnd[5:4];
    assign w_r    = i_rnd[3:0];

    // EDE for encrypt, DED for decrypt: the middle pass flips direction
    assign w_pass_dec = i_blk_dec ^ (w_pass == 2'd1);

    assign o_key_sel    = i_blk_dec ? (KEY_K3 - w_pass) : w_pass;
    assign o_subkey_idx = w_pass_dec ? (4'd15 - w_r) : w_r;
    assign o_last_round = (w_r == 4'(ROUNDS_PER_PASS - 1));

endmodule

// File: rtl/tdes_block_sequencer.sv
// 3DES block sequencer: pops two words, runs 48 rounds, pushes two
// words, and commits double-buffered keys only between blocks.
module tdes_block_sequencer
    import tdes_pkg::*;
#(
    parameter int CNT_W     = 5,
    parameter int OUT_DEPTH = 24,
    parameter int KEY_WORDS = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] in_cnt,
    input  logic [CNT_W-1:0] out_cnt,
    input  logic             in_head_dec,
    output logic             in_pop,
    output logic             dp_load_hi,
    output logic             dp_load_lo,
    output logic             dp_ip,
    output logic             dp_round_en,
    output logic             dp_last_round,
    output logic [3:0]       subkey_idx,
    output logic [1:0]       key_sel,
    output logic             dp_fp,
    output logic             out_push,
    output logic             out_sel_hi,
    output logic             key_commit,
    output logic             keys_valid,
    output logic             busy,
    output logic             blk_done
);

    localparam int KCW = $clog2(KEY_WORDS + 1);
    localparam logic [CNT_W-1:0] OUT_LIMIT = CNT_W'(OUT_DEPTH - 2);

    state_t         r_state;
    state_t         w_next;
    logic [5:0]     r_rnd;
    logic           r_blk_dec;
    logic [KCW-1:0] r_key_cnt;
    logic           r_key_pend;
    logic           r_keys_valid;

    logic           w_soft;
    logic           w_key_wr;
    logic           w_key_last;
    logic           w_commit;
    logic           w_start;
    logic           w_rnd_last;
    logic [1:0]     w_key_sel;
    logic [3:0]     w_subkey_idx;
    logic           w_last_round;

    assign w_soft     = (mode == MODE_SRST);
    assign w_key_wr   = (mode == MODE_KEY1) || (mode == MODE_KEY2);
    assign w_key_last = w_key_wr && (r_key_cnt == KCW'(KEY_WORDS - 1));
    assign w_commit   = r_key_pend && (r_state == ST_IDLE) && !w_soft;
    assign w_rnd_last = (r_rnd == 6'(TOTAL_ROUNDS - 1));

    // Output space is only checked here; the output FIFO can only drain
    assign w_start = (r_state == ST_IDLE) && (in_cnt >= CNT_W'(2))
                  && (out_cnt <= OUT_LIMIT) && r_keys_valid
                  && !r_key_pend && !w_soft;

    tdes_round_map u_map (
        .i_rnd        (r_rnd),
        .i_blk_dec    (r_blk_dec),
        .o_key_sel    (w_key_sel),
        .o_subkey_idx (w_subkey_idx),
        .o_last_round (w_last_round)
    );

    always_comb begin
        w_next        = r_state;
        in_pop        = 1'b0;
        dp_load_hi    = 1'b0;
        dp_load_lo    = 1'b0;
        dp_ip         = 1'b0;
        dp_round_en   = 1'b0;
        dp_last_round = 1'b0;
        subkey_idx    = 4'd0;
        key_sel       = 2'd0;
        dp_fp         = 1'b0;
        out_push      = 1'b0;
        out_sel_hi    = 1'b0;
        blk_done      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start) w_next = ST_LOAD_HI;
            end
            ST_LOAD_HI: begin
                in_pop     = !w_soft;
                dp_load_hi = !w_soft;
                w_next     = ST_LOAD_LO;
            end
            ST_LOAD_LO: begin
                in_pop     = !w_soft;
                dp_load_lo = !w_soft;
                w_next     = ST_IP;
            end
            ST_IP: begin
                dp_ip  = 1'b1;
                w_next = ST_ROUND;
            end
            ST_ROUND: begin
                dp_round_en   = 1'b1;
                dp_last_round = w_last_round;
                subkey_idx    = w_subkey_idx;
                key_sel       = w_key_sel;
                if (w_rnd_last) w_next = ST_FP;
            end
            ST_FP: begin
                dp_fp  = 1'b1;
                w_next = ST_STORE_HI;
            end
            ST_STORE_HI: begin
                out_push   = !w_soft;
                out_sel_hi = !w_soft;
                w_next     = ST_STORE_LO;
            end
            ST_STORE_LO: begin
                out_push = !w_soft;
                blk_done = !w_soft;
                w_next   = ST_IDLE;
            end
        endcase
        if (w_soft) w_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= ST_IDLE;
            r_rnd        <= 6'd0;
            r_blk_dec    <= 1'b0;
            r_key_cnt    <= '0;
            r_key_pend   <= 1'b0;
            r_keys_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_soft) begin
                r_rnd <= 6'd0;
            end else if (r_state == ST_ROUND) begin
                r_rnd <= w_rnd_last ? 6'd0 : r_rnd + 6'd1;
            end
            if (r_state == ST_LOAD_HI && !w_soft) begin
                r_blk_dec <= in_head_dec;
            end
            if (w_soft) begin
                r_key_cnt  <= '0;
                r_key_pend <= 1'b0;
            end else begin
                if (w_key_wr) begin
                    r_key_cnt <= w_key_last ? '0 : r_key_cnt + KCW'(1);
                end
                if (w_key_last) begin
                    r_key_pend <= 1'b1;
                end else if (w_commit) begin
                    r_key_pend <= 1'b0;
                end
                if (w_commit) r_keys_valid <= 1'b1;
            end
        end
    end

    assign key_commit = w_commit;
    assign keys_valid = r_keys_valid;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_tdes_block_sequencer.sv
// Self-checking bench for tdes_block_sequencer with a
// schedule-table reference model and randomized block traffic.
module tb_tdes_block_sequencer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [2:0] mode;
    logic [4:0] in_cnt;
    logic [4:0] out_cnt;
    logic       in_head_dec;
    logic       in_pop, dp_load_hi, dp_load_lo, dp_ip;
    logic       dp_round_en, dp_last_round;
    logic [3:0] subkey_idx;
    logic [1:0] key_sel;
    logic       dp_fp, out_push, out_sel_hi;
    logic       key_commit, keys_valid, busy, blk_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Key per pass and whether the pass runs in decrypt direction
    int ks_tab [2][3] = '{'{0, 1, 2}, '{2, 1, 0}};
    int dd_tab [2][3] = '{'{0, 1, 0}, '{1, 0, 1}};
    logic [2:0] nk_modes [4] = '{3'd0, 3'd1, 3'd2, 3'd6};

    tdes_block_sequencer dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .mode          (mode),
        .in_cnt        (in_cnt),
        .out_cnt       (out_cnt),
        .in_head_dec   (in_head_dec),
        .in_pop        (in_pop),
        .dp_load_hi    (dp_load_hi),
        .dp_load_lo    (dp_load_lo),
        .dp_ip         (dp_ip),
        .dp_round_en   (dp_round_en),
        .dp_last_round (dp_last_round),
        .subkey_idx    (subkey_idx),
        .key_sel       (key_sel),
        .dp_fp         (dp_fp),
        .out_push      (out_push),
        .out_sel_hi    (out_sel_hi),
        .key_commit    (key_commit),
        .keys_valid    (keys_valid),
        .busy          (busy),
        .blk_done      (blk_done)
    );

    always #5 clk = ~clk;

    logic [18:0] obs;
    assign obs = {in_pop, dp_load_hi, dp_load_lo, dp_ip, dp_round_en,
                  dp_last_round, subkey_idx, key_sel, dp_fp, out_push,
                  out_sel_hi, key_commit, keys_valid, busy, blk_done};

    // Expected outputs k cycles after the start decision (k=0: idle)
    function automatic logic [18:0] exp_vec(int k, bit dec, bit kv);
        logic pop, lhi, llo, ip, ren, last, fp, push, shi, done;
        logic [3:0] sk;
        logic [1:0] ks;
        int rnd, pass, r;
        {pop, lhi, llo, ip, ren, last, fp, push, shi, done} = '0;
        sk = 4'd0;
        ks = 2'd0;
        if (k == 1) begin pop = 1; lhi = 1; end
        if (k == 2) begin pop = 1; llo = 1; end
        if (k == 3) ip = 1;
        if (k >= 4 && k <= 51) begin
            rnd  = k - 4;
            pass = rnd / 16;
            r    = rnd % 16;
            ren  = 1;
            last = (r == 15);
            ks   = 2'(ks_tab[dec][pass]);
            sk   = (dd_tab[dec][pass] != 0) ? 4'(15 - r) : 4'(r);
        end
        if (k == 52) fp = 1;
        if (k == 53) begin push = 1; shi = 1; end
        if (k == 54) begin push = 1; done = 1; end
        return {pop, lhi, llo, ip, ren, last, sk, ks, fp, push, shi,
                1'b0, kv, (k >= 1 && k <= 54), done};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input bit dec, input logic [4:0] n_in,
                             input string nm);
        int done_at = -1;
        logic [18:0] e;
        in_head_dec = dec;
        in_cnt      = n_in;
        for (int k = 0; k <= 55; k++) begin
            if (k == 1) in_cnt = 5'd0;
            #1;
            e = exp_vec(k, dec, 1'b1);
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL %s k=%0d: got %h want %h", nm, k, obs, e);
            end
            if (blk_done === 1'b1 && done_at < 0) done_at = k;
            step();
        end
        n_tests++;
        if (done_at != 54) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want 54", nm, done_at);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        mode = 3'd0; in_cnt = 5'd0; out_cnt = 5'd0; in_head_dec = 1'b0;
        repeat (2) step();
        n_tests++;
        if (obs !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h want 0", obs);
        end
        n_rst = 1'b1;
        step();
        n_tests++;
        if (obs !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_release: got %h want 0", obs);
        end
        in_cnt = 5'd2;
        repeat (3) step();
        n_tests++;
        if ({busy, in_pop} !== 2'b00) begin
            n_fail++;
            $display("FAIL no_keys_start: got %b want 00", {busy, in_pop});
        end
        in_cnt = 5'd0;
        step();
    endtask

    task automatic test_key_load();
        for (int i = 0; i < 4; i++) begin
            mode = (i % 2 == 0) ? 3'd3 : 3'd4;
            #1;
            n_tests++;
            if (key_commit !== 1'b0) begin
                n_fail++;
                $display("FAIL key_early w%0d: got %b want 0", i, key_commit);
            end
            step();
        end
        mode = 3'd0;
        #1;
        n_tests++;
        if ({key_commit, keys_valid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL key_commit: got %b want 100",
                     {key_commit, keys_valid, busy});
        end
        step();
        n_tests++;
        if ({key_commit, keys_valid, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL key_valid: got %b want 010",
                     {key_commit, keys_valid, busy});
        end
    endtask

    task automatic test_encrypt();
        mode = 3'd1; out_cnt = 5'd0;
        run_block(1'b0, 5'd2, "enc");
    endtask

    task automatic test_decrypt();
        mode = 3'd2; out_cnt = 5'd0;
        run_block(1'b1, 5'd2, "dec");
    endtask

    task automatic test_out_space();
        mode = 3'd0; in_cnt = 5'd4; out_cnt = 5'd23;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if ({busy, in_pop} !== 2'b00) begin
                n_fail++;
                $display("FAIL out_full c%0d: got %b want 00", i,
                         {busy, in_pop});
            end
            step();
        end
        out_cnt = 5'd22;
        run_block(1'b0, 5'd4, "out_space");
    endtask

    task automatic test_back_to_back();
        logic [18:0] e;
        mode = 3'd0; out_cnt = 5'd0; in_cnt = 5'd2; in_head_dec = 1'b1;
        for (int k = 0; k <= 110; k++) begin
            if (k == 2) in_head_dec = 1'b0;
            if (k == 56) in_cnt = 5'd0;
            #1;
            e = (k <= 54) ? exp_vec(k, 1'b1, 1'b1)
                          : exp_vec(k - 55, 1'b0, 1'b1);
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL b2b k=%0d: got %h want %h", k, obs, e);
            end
            step();
        end
    endtask

    task automatic test_key_mid_block();
        logic [18:0] e;
        int seen = 0;
        mode = 3'd0; out_cnt = 5'd0; in_cnt = 5'd2; in_head_dec = 1'b0;
        for (int k = 0; k <= 54; k++) begin
            mode = (k >= 14 && k <= 17) ? 3'd3 + 3'(k % 2) : 3'd0;
            #1;
            e = exp_vec(k, 1'b0, 1'b1);
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL key_mid k=%0d: got %h want %h", k, obs, e);
            end
            step();
        end
        mode = 3'd0;
        #1;
        n_tests++;
        if ({key_commit, busy, in_pop} !== 3'b100) begin
            n_fail++;
            $display("FAIL key_mid_commit: got %b want 100",
                     {key_commit, busy, in_pop});
        end
        step();
        n_tests++;
        if ({key_commit, busy, in_pop} !== 3'b000) begin
            n_fail++;
            $display("FAIL key_mid_blocked: got %b want 000",
                     {key_commit, busy, in_pop});
        end
        step();
        n_tests++;
        if ({busy, in_pop} !== 2'b11) begin
            n_fail++;
            $display("FAIL key_mid_restart: got %b want 11", {busy, in_pop});
        end
        in_cnt = 5'd0;
        for (int i = 0; i < 60 && seen == 0; i++) begin
            if (blk_done === 1'b1) seen = 1;
            step();
        end
        n_tests++;
        if (seen == 0) begin
            n_fail++;
            $display("FAIL key_mid_drain: got no blk_done want blk_done");
        end
        step();
    endtask

    task automatic test_soft_reset();
        logic [18:0] e;
        mode = 3'd0; out_cnt = 5'd0; in_cnt = 5'd2; in_head_dec = 1'b0;
        for (int k = 0; k <= 34; k++) begin
            if (k == 1) in_cnt = 5'd0;
            if (k == 34) mode = 3'd5;
            #1;
            e = exp_vec(k, 1'b0, 1'b1);
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL srst k=%0d: got %h want %h", k, obs, e);
            end
            step();
        end
        mode = 3'd0;
        for (int i = 0; i < 25; i++) begin
            #1;
            n_tests++;
            if ({busy, out_push, in_pop, keys_valid} !== 4'b0001) begin
                n_fail++;
                $display("FAIL srst_idle c%0d: got %b want 0001", i,
                         {busy, out_push, in_pop, keys_valid});
            end
            step();
        end
        for (int i = 0; i < 5; i++) begin
            mode = (i == 3) ? 3'd5 : 3'd3;
            step();
        end
        mode = 3'd0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests++;
            if (key_commit !== 1'b0) begin
                n_fail++;
                $display("FAIL srst_keycnt c%0d: got %b want 0", i,
                         key_commit);
            end
            step();
        end
        mode = 3'd4;
        repeat (3) step();
        mode = 3'd0;
        #1;
        n_tests++;
        if (key_commit !== 1'b1) begin
            n_fail++;
            $display("FAIL srst_recommit: got %b want 1", key_commit);
        end
        step();
        run_block(1'b0, 5'd2, "srst_next");
    endtask

    task automatic test_random();
        int gap;
        for (int it = 0; it < 8; it++) begin
            gap = $urandom_range(1, 4);
            for (int g = 0; g < gap; g++) begin
                mode = nk_modes[$urandom_range(0, 3)];
                if ($urandom_range(0, 1) == 0) begin
                    in_cnt  = 5'($urandom_range(0, 1));
                    out_cnt = 5'($urandom_range(0, 22));
                end else begin
                    in_cnt  = 5'($urandom_range(2, 31));
                    out_cnt = 5'($urandom_range(23, 31));
                end
                #1;
                n_tests++;
                if ({busy, in_pop} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL rnd_gap it%0d: got %b want 00", it,
                             {busy, in_pop});
                end
                step();
            end
            out_cnt = 5'($urandom_range(0, 22));
            run_block(1'($urandom_range(0, 1)),
                      5'($urandom_range(2, 31)), "rnd_blk");
        end
    endtask

    initial begin
        test_reset();
        test_key_load();
        test_encrypt();
        test_decrypt();
        test_out_space();
        test_back_to_back();
        test_key_mid_block();
        test_soft_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
